// File: rtl/oled_pkg.sv
// Shared encodings, sizes and SSD1306 addressing constants for the OLED sequencer.
package oled_pkg;

    localparam int unsigned INIT_LEN  = 27;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned PAGE_W    = 3;
    localparam int unsigned COL_W     = 7;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_PAGES = 8;
    localparam int unsigned NUM_COLS  = 128;

    localparam logic [IDX_W-1:0]  INIT_LAST = IDX_W'(INIT_LEN - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLS - 1);

    localparam logic [BYTE_W-1:0] PAGE_BASE = 8'hB0;
    localparam logic [BYTE_W-1:0] COL_LO    = 8'h00;
    localparam logic [BYTE_W-1:0] COL_HI    = 8'h10;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_CLR_CMD,
        ST_CLR_DATA,
        ST_IDLE,
        ST_WR_CMD,
        ST_WR_DATA
    } state_t;

    typedef enum logic [1:0] {
        PH_REQ,
        PH_WAIT_LO,
        PH_WAIT_HI
    } phase_t;

    typedef struct packed {
        logic [PAGE_W-1:0] page;
        logic [COL_W-1:0]  col;
        logic [BYTE_W-1:0] data;
    } wr_req_t;

    // Three-byte page/column address preamble: page select, column low nibble, column high bits.
    function automatic logic [BYTE_W-1:0] addr_cmd(input logic [1:0]        sel,
                                                   input logic [PAGE_W-1:0] page,
                                                   input logic [COL_W-1:0]  col);
        logic [BYTE_W-1:0] cmd;
        case (sel)
            2'd0:    cmd = PAGE_BASE | {5'b0, page};
            2'd1:    cmd = COL_LO | {4'h0, col[3:0]};
            default: cmd = COL_HI | {5'b0, col[6:4]};
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// SSD1306 128x64 power-on command list, indexed 0..26.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [IDX_W-1:0]  idx_i,
    output logic [BYTE_W-1:0] cmd_o
);

    always_comb begin
        cmd_o = 8'hE3;
        case (idx_i)
            5'd0:    cmd_o = 8'hAE;
            5'd1:    cmd_o = 8'h00;
            5'd2:    cmd_o = 8'h10;
            5'd3:    cmd_o = 8'h40;
            5'd4:    cmd_o = 8'hB0;
            5'd5:    cmd_o = 8'h81;
            5'd6:    cmd_o = 8'hFF;
            5'd7:    cmd_o = 8'hA1;
            5'd8:    cmd_o = 8'hA6;
            5'd9:    cmd_o = 8'hA8;
            5'd10:   cmd_o = 8'h3F;
            5'd11:   cmd_o = 8'hC8;
            5'd12:   cmd_o = 8'hD3;
            5'd13:   cmd_o = 8'h00;
            5'd14:   cmd_o = 8'hD5;
            5'd15:   cmd_o = 8'h80;
            5'd16:   cmd_o = 8'hD8;
            5'd17:   cmd_o = 8'h05;
            5'd18:   cmd_o = 8'hD9;
            5'd19:   cmd_o = 8'hF1;
            5'd20:   cmd_o = 8'hDA;
            5'd21:   cmd_o = 8'h12;
            5'd22:   cmd_o = 8'hDB;
            5'd23:   cmd_o = 8'h30;
            5'd24:   cmd_o = 8'h8D;
            5'd25:   cmd_o = 8'h14;
            5'd26:   cmd_o = 8'hAF;
            default: cmd_o = 8'hE3;
        endcase
    end

endmodule

// File: rtl/oled_ctrl.sv
// SSD1306 sequencer in front of the IIC byte writer: init list, full clear, then host pixel writes.
// Optional power-up wait enabled by defining OLED_CTRL_PWRUP_DELAY_EN.
module oled_ctrl
    import oled_pkg::*;
#(
    parameter logic [23:0]       PWRUP_CYC = 24'd5_000_000,
    parameter logic [BYTE_W-1:0] CLR_BYTE  = 8'h00
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    output logic              iic_exec,
    output logic              iic_w_ctrl,
    output logic [BYTE_W-1:0] iic_w_data,
    input  logic              iic_done,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [PAGE_W-1:0] wr_page,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              init_done,
    output logic              busy
);

    state_t            state_q;
    phase_t            phase_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        sub_q;
    logic [PAGE_W-1:0] page_q;
    logic [COL_W-1:0]  col_q;
    wr_req_t           req_q;
    logic              exec_q;
    logic              ctrl_q;
    logic [BYTE_W-1:0] data_q;
    logic              ready_q;
    logic              init_done_q;
    logic              busy_q;

    logic [BYTE_W-1:0] rom_cmd;
    logic              byte_ctrl_c;
    logic [BYTE_W-1:0] byte_data_c;

`ifdef OLED_CTRL_PWRUP_DELAY_EN
    logic [23:0]       pwr_cnt_q;
`else
    logic              unused_pwrup;
    assign unused_pwrup = ^PWRUP_CYC;
`endif

    oled_init_rom u_rom (
        .idx_i (idx_q),
        .cmd_o (rom_cmd)
    );

    // Byte the current state would send on its next request.
    always_comb begin
        byte_ctrl_c = 1'b1;
        byte_data_c = rom_cmd;
        case (state_q)
            ST_CLR_CMD:  byte_data_c = addr_cmd(sub_q, page_q, '0);
            ST_CLR_DATA: begin
                byte_ctrl_c = 1'b0;
                byte_data_c = CLR_BYTE;
            end
            ST_WR_CMD:   byte_data_c = addr_cmd(sub_q, req_q.page, req_q.col);
            ST_WR_DATA: begin
                byte_ctrl_c = 1'b0;
                byte_data_c = req_q.data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_PWRUP;
            phase_q     <= PH_REQ;
            idx_q       <= '0;
            sub_q       <= '0;
            page_q      <= '0;
            col_q       <= '0;
            req_q       <= '0;
            exec_q      <= 1'b0;
            ctrl_q      <= 1'b0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef OLED_CTRL_PWRUP_DELAY_EN
            pwr_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_PWRUP: begin
`ifdef OLED_CTRL_PWRUP_DELAY_EN
                    if (pwr_cnt_q == PWRUP_CYC - 24'd1) begin
                        state_q <= ST_INIT;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 24'd1;
                    end
`else
                    state_q <= ST_INIT;
`endif
                end
                ST_IDLE: begin
                    if (wr_valid && ready_q) begin
                        req_q.page <= wr_page;
                        req_q.col  <= wr_col;
                        req_q.data <= wr_data;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        sub_q      <= '0;
                        state_q    <= ST_WR_CMD;
                    end
                end
                default: begin
                    // Per-byte handshake: request only into an idle writer, drop exec once it goes busy.
                    case (phase_q)
                        PH_REQ: begin
                            if (iic_done) begin
                                exec_q  <= 1'b1;
                                ctrl_q  <= byte_ctrl_c;
                                data_q  <= byte_data_c;
                                phase_q <= PH_WAIT_LO;
                            end
                        end
                        PH_WAIT_LO: begin
                            if (!iic_done) begin
                                exec_q  <= 1'b0;
                                phase_q <= PH_WAIT_HI;
                            end
                        end
                        PH_WAIT_HI: begin
                            if (iic_done) begin
                                phase_q <= PH_REQ;
                                case (state_q)
                                    ST_INIT: begin
                                        if (idx_q == INIT_LAST) begin
                                            state_q <= ST_CLR_CMD;
                                            page_q  <= '0;
                                            sub_q   <= '0;
                                        end else begin
                                            idx_q <= idx_q + 5'd1;
                                        end
                                    end
                                    ST_CLR_CMD: begin
                                        if (sub_q == 2'd2) begin
                                            state_q <= ST_CLR_DATA;
                                            col_q   <= '0;
                                        end else begin
                                            sub_q <= sub_q + 2'd1;
                                        end
                                    end
                                    ST_CLR_DATA: begin
                                        if (col_q != COL_LAST) begin
                                            col_q <= col_q + 7'd1;
                                        end else if (page_q == PAGE_LAST) begin
                                            state_q     <= ST_IDLE;
                                            init_done_q <= 1'b1;
                                            ready_q     <= 1'b1;
                                            busy_q      <= 1'b0;
                                        end else begin
                                            page_q  <= page_q + 3'd1;
                                            sub_q   <= '0;
                                            state_q <= ST_CLR_CMD;
                                        end
                                    end
                                    ST_WR_CMD: begin
                                        if (sub_q == 2'd2) begin
                                            state_q <= ST_WR_DATA;
                                        end else begin
                                            sub_q <= sub_q + 2'd1;
                                        end
                                    end
                                    ST_WR_DATA: begin
                                        state_q <= ST_IDLE;
                                        ready_q <= 1'b1;
                                        busy_q  <= 1'b0;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        default: phase_q <= PH_REQ;
                    endcase
                end
            endcase
        end
    end

    assign iic_exec   = exec_q;
    assign iic_w_ctrl = ctrl_q;
    assign iic_w_data = data_q;
    assign wr_ready   = ready_q;
    assign init_done  = init_done_q;
    assign busy       = busy_q;

endmodule
